cell_toggle_monitor: RTL and testbench

//  Downstream observer for a combinational cell output, such as QN of an OAI22X2 under power characterisation.

---
 rtl/cell_monitor_pkg.sv | 8 +
 rtl/cell_sat_counter.sv | 33 +++
 rtl/cell_toggle_monitor.sv | 123 ++++++++++++
 tb/tb_cell_toggle_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cell_monitor_pkg.sv
// cell_monitor_pkg: shared types and defaults for the cell toggle monitor slice.
package cell_monitor_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam int unsigned CW_DEFAULT = 16;

endpackage

// File: rtl/cell_sat_counter.sv
// cell_sat_counter: saturating up-counter with synchronous clear.
// sat flags an increment that leaves the counter at all-ones, so the sticky overflow lands on the same edge.
module cell_sat_counter
  import cell_monitor_pkg::*;
#(
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] MAX_M1 = {{(CW-1){1'b1}}, 1'b0};

  logic at_max;

  assign at_max = (cnt == '1);
  assign sat    = inc & (at_max | (cnt == MAX_M1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cell_toggle_monitor.sv
// cell_toggle_monitor: counts rising/falling edges and high cycles of SIG over a measurement window.
// Define STUCK_DETECT_EN to build the stuck-output detector; otherwise STUCK is tied low.
module cell_toggle_monitor
  import cell_monitor_pkg::*;
#(
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned STUCK_LIM = 64
) (
  input  logic          CLK,
  input  logic          RSTB,
  input  logic          SIG,
  input  logic          START,
  input  logic          STOP,
  input  logic          CLR,
  input  logic [CW-1:0] WIN_LEN,
  output logic [CW-1:0] RISE_CNT,
  output logic [CW-1:0] FALL_CNT,
  output logic [CW-1:0] HIGH_CNT,
  output logic [CW-1:0] WIN_CNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF,
  output logic          STUCK
);

  if (CW < 2 || STUCK_LIM < 1) begin : g_bad_cfg
    $error("cell_toggle_monitor: CW must be >= 2 and STUCK_LIM >= 1");
  end

  cell_monitor_pkg::state_t state;
  logic       s_q;
  logic       in_arm, in_run, rise, fall, win_end, cnt_clr;
  logic [3:0] sat;

  assign in_arm  = (state == cell_monitor_pkg::ARM);
  assign in_run  = (state == cell_monitor_pkg::RUN);
  assign rise    = in_run & SIG & ~s_q;
  assign fall    = in_run & ~SIG & s_q;
  assign cnt_clr = CLR | in_arm;
  // Compare one bit wider so a saturated WIN_CNT can never wrap onto WIN_LEN.
  assign win_end = STOP | ((WIN_LEN != '0) &&
                   (({1'b0, WIN_CNT} + (CW+1)'(1)) == {1'b0, WIN_LEN}));

  cell_sat_counter #(.CW(CW)) u_rise (
    .clk(CLK), .rst_n(RSTB), .clr(cnt_clr), .inc(rise), .cnt(RISE_CNT), .sat(sat[0])
  );
  cell_sat_counter #(.CW(CW)) u_fall (
    .clk(CLK), .rst_n(RSTB), .clr(cnt_clr), .inc(fall), .cnt(FALL_CNT), .sat(sat[1])
  );
  cell_sat_counter #(.CW(CW)) u_high (
    .clk(CLK), .rst_n(RSTB), .clr(cnt_clr), .inc(in_run & SIG), .cnt(HIGH_CNT), .sat(sat[2])
  );
  cell_sat_counter #(.CW(CW)) u_win (
    .clk(CLK), .rst_n(RSTB), .clr(cnt_clr), .inc(in_run), .cnt(WIN_CNT), .sat(sat[3])
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state <= cell_monitor_pkg::IDLE;
      s_q   <= 1'b0;
      OVF   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else if (CLR) begin
      state <= cell_monitor_pkg::IDLE;
      s_q   <= 1'b0;
      OVF   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        cell_monitor_pkg::IDLE, cell_monitor_pkg::DONE: begin
          if (START) begin
            state <= cell_monitor_pkg::ARM;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
          end
        end
        cell_monitor_pkg::ARM: begin
          state <= cell_monitor_pkg::RUN;
          s_q   <= SIG;
          OVF   <= 1'b0;
        end
        cell_monitor_pkg::RUN: begin
          s_q <= SIG;
          OVF <= OVF | (|sat);
          if (win_end) begin
            state <= cell_monitor_pkg::DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= cell_monitor_pkg::IDLE;
      endcase
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int unsigned QW = $clog2(STUCK_LIM + 1);

  logic [QW-1:0] quiet;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      quiet <= '0;
      STUCK <= 1'b0;
    end else if (CLR || in_arm) begin
      quiet <= '0;
      STUCK <= 1'b0;
    end else if (in_run) begin
      if (rise || fall) begin
        quiet <= '0;
      end else if (quiet != QW'(STUCK_LIM)) begin
        quiet <= quiet + QW'(1);
        if (quiet == QW'(STUCK_LIM - 1)) STUCK <= 1'b1;
      end
    end
  end
`else
  assign STUCK = 1'b0;
`endif

endmodule

// File: tb/tb_cell_toggle_monitor.sv
// tb_cell_toggle_monitor: randomized windows checked against a per-window reference model,
// plus directed reset/clear/saturation scenarios on a narrow CW=4 instance.
module tb_cell_toggle_monitor;

  localparam int unsigned CW  = 16;
  localparam int unsigned LIM = 8;
`ifdef STUCK_DETECT_EN
  localparam bit STUCK_ON = 1'b1;
`else
  localparam bit STUCK_ON = 1'b0;
`endif

  logic          clk = 1'b0, rstb = 1'b0;
  logic          sig = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic [CW-1:0] win_len = '0;
  logic [CW-1:0] rise_cnt, fall_cnt, high_cnt, win_cnt;
  logic          busy, done, ovf, stuck;

  logic          sig4 = 1'b0, start4 = 1'b0, stop4 = 1'b0, clr4 = 1'b0;
  logic [3:0]    win_len4 = '0;
  logic [3:0]    rise4, fall4, high4, win4;
  logic          busy4, done4, ovf4, stuck4;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state for the current window
  int m_rise, m_fall, m_high, m_win, m_quiet;
  bit m_prev, m_stuck;

  cell_toggle_monitor #(.CW(CW), .STUCK_LIM(LIM)) u_dut (
    .CLK(clk), .RSTB(rstb), .SIG(sig), .START(start), .STOP(stop), .CLR(clr),
    .WIN_LEN(win_len), .RISE_CNT(rise_cnt), .FALL_CNT(fall_cnt), .HIGH_CNT(high_cnt),
    .WIN_CNT(win_cnt), .BUSY(busy), .DONE(done), .OVF(ovf), .STUCK(stuck)
  );

  cell_toggle_monitor #(.CW(4)) u_dut4 (
    .CLK(clk), .RSTB(rstb), .SIG(sig4), .START(start4), .STOP(stop4), .CLR(clr4),
    .WIN_LEN(win_len4), .RISE_CNT(rise4), .FALL_CNT(fall4), .HIGH_CNT(high4),
    .WIN_CNT(win4), .BUSY(busy4), .DONE(done4), .OVF(ovf4), .STUCK(stuck4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rise"},  rise_cnt, 0);
    check({tag, "_fall"},  fall_cnt, 0);
    check({tag, "_high"},  high_cnt, 0);
    check({tag, "_win"},   win_cnt,  0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_done"},  done,     0);
    check({tag, "_ovf"},   ovf,      0);
    check({tag, "_stuck"}, stuck,    0);
  endtask

  // pattern: 0 = constant baseline, 1 = toggle every cycle, 2 = random
  task automatic run_window(input int n, input int stop_at, input bit b,
                            input bit stop_with_start, input int pattern);
    int len;
    bit s;
    start = 1'b1; stop = stop_with_start; sig = b; win_len = CW'(n);
    tick();
    start = 1'b0; stop = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_done", done, 0);
    tick();
    m_rise = 0; m_fall = 0; m_high = 0; m_win = 0; m_quiet = 0; m_stuck = 1'b0; m_prev = b;
    len = (n != 0 && (stop_at < 0 || stop_at >= n)) ? n : stop_at + 1;
    for (int i = 0; i < len; i++) begin
      case (pattern)
        0:       s = b;
        1:       s = ~m_prev;
        default: s = 1'($urandom_range(0, 1));
      endcase
      sig = s; stop = (i == stop_at);
      tick();
      m_win++;
      if (s) m_high++;
      if (s && !m_prev) m_rise++;
      if (!s && m_prev) m_fall++;
      m_quiet = (s == m_prev) ? m_quiet + 1 : 0;
      if (m_quiet >= int'(LIM)) m_stuck = 1'b1;
      m_prev = s;
      check("run_win", win_cnt, m_win);
      check("run_rise", rise_cnt, m_rise);
      check("run_busy", busy, (i == len - 1) ? 0 : 1);
    end
    stop = 1'b0;
    check("end_rise", rise_cnt, m_rise);
    check("end_fall", fall_cnt, m_fall);
    check("end_high", high_cnt, m_high);
    check("end_win", win_cnt, m_win);
    check("end_done", done, 1);
    check("end_ovf", ovf, 0);
    check("end_stuck", stuck, STUCK_ON & m_stuck);
    repeat (2) begin
      sig = ~sig;
      tick();
    end
    check("hold_win", win_cnt, m_win);
    check("hold_fall", fall_cnt, m_fall);
    check("hold_done", done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int r4, f4, h4, w4;
    bit p4;

    repeat (2) tick();
    check_zero("reset");
    check("reset_busy4", busy4, 0);
    rstb = 1'b1;
    tick();

    // START and STOP together in IDLE: STOP ignored, window ends on the later STOP
    run_window(0, 36, 1'b0, 1'b1, 2);
    run_window(8, -1, 1'b1, 1'b0, 0);
    run_window(10, -1, 1'b0, 1'b0, 1);
    run_window(1, -1, 1'b0, 1'b0, 2);
    run_window(5, 0, 1'b1, 1'b0, 2);

    for (int k = 0; k < 25; k++) begin
      int n, sa;
      n  = int'($urandom_range(0, 20));
      sa = (n == 0) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, n + 5));
      if (sa >= n && n != 0) sa = -1;
      run_window(n, sa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
    end

    // asynchronous reset mid-window
    start = 1'b1; win_len = '0; sig = 1'b0;
    tick();
    start = 1'b0;
    repeat (6) begin
      sig = ~sig;
      tick();
    end
    rstb = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    rstb = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // synchronous clear mid-window
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) begin
      sig = ~sig;
      tick();
    end
    check("pre_clr_busy", busy, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_zero("clr");

    // CLR beats START
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    tick();
    check("clr_start_busy", busy, 0);

    // narrow instance: toggling saturates RISE/FALL/HIGH/WIN, RUN continues
    start4 = 1'b1; sig4 = 1'b0;
    tick();
    start4 = 1'b0;
    tick();
    r4 = 0; f4 = 0; h4 = 0; w4 = 0; p4 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sig4 = ~p4;
      tick();
      w4++;
      if (sig4) h4++;
      if (sig4 && !p4) r4++;
      if (!sig4 && p4) f4++;
      p4 = sig4;
      check("sat_ovf", ovf4, (r4 >= 15 || f4 >= 15 || h4 >= 15 || w4 >= 15) ? 1 : 0);
    end
    check("sat_rise", rise4, (r4 > 15) ? 15 : r4);
    check("sat_fall", fall4, (f4 > 15) ? 15 : f4);
    check("sat_high", high4, (h4 > 15) ? 15 : h4);
    check("sat_win", win4, (w4 > 15) ? 15 : w4);
    check("sat_busy", busy4, 1);
    check("sat_done", done4, 0);
    check("sat_stuck", stuck4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
